bloom_count_query_sequencer: RTL and testbench
==============================================

Name: bloom_count_query_sequencer

Overview:
- Sequences one counting-Bloom-filter membership/count query over a shared counter RAM.
- Accepts a query carrying NUM_HASHES precomputed counter addresses and issues one RAM read per address through a request/grant port.
- Folds each returned counter into a running minimum and presents the count-min estimate plus a membership bit on a valid/ready result port.
- Sits between the hash stage and the result consumer, next to the counter RAM arbiter.

Parameters:
- NUM_HASHES, 7: addresses per query (>=1).
- ADDR_WIDTH, 20: counter RAM address width.
- COUNT_WIDTH, 4: width of one counter.
- CNT_WIDTH, $clog2(NUM_HASHES+1): width of the issue and response counters.

Ports:
- clk  in  1  clock.
- rstb  in  1  asynchronous active-low reset.
- queryValid  in  1  query present.
- queryReady  out  1  sequencer can accept a query.
- queryAddrs  in  NUM_HASHES*ADDR_WIDTH  address i in bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
- memReadReq  out  1  read request to arbiter.
- memReadGnt  in  1  request accepted this cycle.
- memReadAddr  out  ADDR_WIDTH  read address; valid while memReadReq.
- memRspValid  in  1  read data returned; responses arrive in issue order, any latency >= 1.
- memRspData  in  COUNT_WIDTH  counter value.
- resultValid  out  1  result available.
- resultReady  in  1  consumer takes result.
- resultMinimum  out  COUNT_WIDTH  minimum of the NUM_HASHES counters.
- resultIsMember  out  1  resultMinimum != 0.
- busy  out  1  state != IDLE.
- protocolError  out  1  sticky: a response arrived with no read outstanding.

Behaviour:
- Reset (rstb low, asynchronous): state=IDLE; counters=0; running minimum = all ones; protocolError=0.
  - resultValid=0, memReadReq=0, busy=0.
  - queryReady=1, since it is a decode of IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - queryReady=1.
  - On queryValid: register all addresses, clear issueCnt and rspCnt, set running minimum to all ones, go to ISSUE.
- ISSUE:
  - memReadReq=1; memReadAddr = captured address[issueCnt].
  - On memReadGnt, issueCnt++.
  - On the grant of address NUM_HASHES-1: go to DRAIN, or to DONE if that same cycle completes the final response.
- Response handling (ISSUE or DRAIN, same cycle as grants if coincident):
  - On memRspValid: min <= (memRspData < min) ? memRspData : min; rspCnt++.
  - Equal values keep the current minimum.
  - When rspCnt reaches NUM_HASHES (counting this cycle's response), go to DONE. The result register then holds the final minimum, including the last response.
- DRAIN: memReadReq=0; wait for the remaining responses.
- DONE:
  - resultValid=1; resultMinimum and resultIsMember are stable.
  - On resultReady, go to IDLE.
  - A new query is accepted no earlier than the following cycle; there is no query/result overlap.
- Latency (grant always high, RAM latency L):
  - Query accepted at cycle 0; reads issued at cycles 1..NUM_HASHES.
  - resultValid at cycle NUM_HASHES+L+1.
  - Throughput: one query per NUM_HASHES+L+2 cycles with resultReady held high.
- Grant deasserted mid-ISSUE: the address holds and the request stays asserted; no address is skipped or repeated.
- memRspValid in IDLE or DONE, or beyond NUM_HASHES responses: ignored (minimum and rspCnt unchanged) and protocolError set. It clears only on reset.
- Reset mid-operation: immediate return to IDLE. The integrator must reset the RAM/arbiter together so that stale responses are not flagged.
- Saturated counters: all-ones inputs give resultMinimum all ones and resultIsMember=1.
- NUM_HASHES=1: ISSUE lasts one granted cycle, then DRAIN.

Decomposition:
- Shared package bloom_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the default COUNT_WIDTH and ADDR_WIDTH constants;
  - a function for the counter width of NUM_HASHES.
- One natural sub-module, count_min_accumulator: holds the running minimum and rspCnt, with clear/update/done interface. The FSM and issue logic stay in the top.

Test Plan:
- Grant always high, L=2, NUM_HASHES=7, counters {5,3,9,3,7,4,6} -> resultMinimum=3, resultIsMember=1, resultValid at cycle 10, reads issued on consecutive cycles in address order.
- One counter is 0 among {2,2,0,8,1,1,4} -> resultMinimum=0, resultIsMember=0.
- Grant toggled 1,0,0,1,... -> each address appears exactly once on a granted cycle, in order; result equals the min of the returned data.
- resultReady held low for 5 cycles -> resultValid and resultMinimum stable, queryReady=0, no new reads; a back-to-back query is accepted the cycle after the result handshake.
- Spurious memRspValid in IDLE -> protocolError=1 and the next query's result is unaffected. Assert rstb mid-ISSUE -> all outputs at reset values asynchronously, then a fresh query completes correctly.
- All counters 15 (COUNT_WIDTH=4) -> resultMinimum=15. NUM_HASHES=1 build -> result equals the single counter.

Source files
------------

// File: rtl/bloom_count_query_sequencer_pkg.sv
// Shared types and defaults for the counting-Bloom-filter query sequencer.
//   state_e      : sequencer FSM states
//   DEF_*        : default NUM_HASHES / ADDR_WIDTH / COUNT_WIDTH
//   cnt_width()  : width of a counter able to hold 0..n
package bloom_pkg;

  localparam int unsigned DEF_NUM_HASHES  = 7;
  localparam int unsigned DEF_ADDR_WIDTH  = 20;
  localparam int unsigned DEF_COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to count from 0 up to and including n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bloom_count_query_sequencer_if.sv
// Query, counter-RAM read and result handshake bundle.
//   master : the sequencer side (accepts queries, issues reads, presents results)
//   slave  : the environment side (hash stage, RAM arbiter, result consumer)
interface bloom_count_query_sequencer_if #(
  parameter int unsigned NUM_HASHES  = bloom_pkg::DEF_NUM_HASHES,
  parameter int unsigned ADDR_WIDTH  = bloom_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = bloom_pkg::DEF_COUNT_WIDTH
) ();

  logic                             queryValid;
  logic                             queryReady;
  logic [NUM_HASHES*ADDR_WIDTH-1:0] queryAddrs;
  logic                             memReadReq;
  logic                             memReadGnt;
  logic [ADDR_WIDTH-1:0]            memReadAddr;
  logic                             memRspValid;
  logic [COUNT_WIDTH-1:0]           memRspData;
  logic                             resultValid;
  logic                             resultReady;
  logic [COUNT_WIDTH-1:0]           resultMinimum;
  logic                             resultIsMember;

  modport master (
    input  queryValid, queryAddrs, memReadGnt, memRspValid, memRspData, resultReady,
    output queryReady, memReadReq, memReadAddr, resultValid, resultMinimum, resultIsMember
  );

  modport slave (
    output queryValid, queryAddrs, memReadGnt, memRspValid, memRspData, resultReady,
    input  queryReady, memReadReq, memReadAddr, resultValid, resultMinimum, resultIsMember
  );

endinterface

// File: rtl/bloom_count_query_sequencer_accum.sv
// Running count-min accumulator for one query.
//   i_clear  : start a new query (min = all ones, count = 0)
//   i_update : fold i_data into the running minimum and count it
//   o_min    : running minimum
//   o_rsp_cnt: responses folded so far
//   o_done_c : this cycle's update is the final (NUM_HASHES-th) response
module count_min_accumulator
  import bloom_pkg::*;
#(
  parameter int unsigned NUM_HASHES  = DEF_NUM_HASHES,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned CNT_WIDTH   = cnt_width(NUM_HASHES)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   i_clear,
  input  logic                   i_update,
  input  logic [COUNT_WIDTH-1:0] i_data,
  output logic [COUNT_WIDTH-1:0] o_min,
  output logic [CNT_WIDTH-1:0]   o_rsp_cnt,
  output logic                   o_done_c
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  logic [COUNT_WIDTH-1:0] r_min;
  logic [CNT_WIDTH-1:0]   r_rsp_cnt;
  logic [CW1-1:0]         w_cnt_inc;

  // One extra bit so the compare against NUM_HASHES never wraps.
  assign w_cnt_inc = CW1'(r_rsp_cnt) + CW1'(1);
  assign o_done_c  = i_update && (w_cnt_inc == CW1'(NUM_HASHES));

  // Minimum and response count; equal values leave the minimum alone.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_min     <= '1;
      r_rsp_cnt <= '0;
    end else if (i_clear) begin
      r_min     <= '1;
      r_rsp_cnt <= '0;
    end else if (i_update) begin
      if (i_data < r_min) r_min <= i_data;
      r_rsp_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
    end
  end

  assign o_min     = r_min;
  assign o_rsp_cnt = r_rsp_cnt;

endmodule

// File: rtl/bloom_count_query_sequencer.sv
// Sequences one counting-Bloom-filter query: captures NUM_HASHES addresses,
// issues one counter-RAM read per address through a request/grant port,
// folds responses into a running minimum and presents the count-min estimate.
//   clk, rstb     : clock, asynchronous active-low reset
//   bus (master)  : query in, RAM read request/response, result out
//   busy          : FSM not idle
//   protocolError : sticky, a response arrived with no read outstanding
module bloom_count_query_sequencer
  import bloom_pkg::*;
#(
  parameter int unsigned NUM_HASHES  = DEF_NUM_HASHES,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned CNT_WIDTH   = cnt_width(NUM_HASHES)
) (
  input  logic                          clk,
  input  logic                          rstb,
  bloom_count_query_sequencer_if.master bus,
  output logic                          busy,
  output logic                          protocolError
);

  localparam int unsigned QW = NUM_HASHES * ADDR_WIDTH;

  state_e                 r_state;
  state_e                 w_next;
  logic [QW-1:0]          r_addr_q;
  logic [CNT_WIDTH-1:0]   r_issue_cnt;
  logic                   r_protocol_error;

  logic                   w_accept;
  logic                   w_grant;
  logic                   w_last_grant;
  logic                   w_rsp_ok;
  logic                   w_done_c;
  logic [COUNT_WIDTH-1:0] w_min;
  logic [CNT_WIDTH-1:0]   w_rsp_cnt;

  assign w_accept     = (r_state == IDLE) && bus.queryValid;
  assign w_grant      = (r_state == ISSUE) && bus.memReadGnt;
  assign w_last_grant = w_grant && (r_issue_cnt == CNT_WIDTH'(NUM_HASHES - 1));
  // A response is legal only while a read is outstanding.
  assign w_rsp_ok     = bus.memRspValid && ((r_state == ISSUE) || (r_state == DRAIN))
                        && (w_rsp_cnt < r_issue_cnt);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.queryValid) w_next = ISSUE;
      ISSUE: begin
        if (w_last_grant)  w_next = w_done_c ? DONE : DRAIN;
        else if (w_done_c) w_next = DONE;
      end
      DRAIN:   if (w_done_c) w_next = DONE;
      DONE:    if (bus.resultReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Captured addresses shift down on each grant so the head is always next.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_addr_q    <= '0;
      r_issue_cnt <= '0;
    end else if (w_accept) begin
      r_addr_q    <= bus.queryAddrs;
      r_issue_cnt <= '0;
    end else if (w_grant) begin
      r_addr_q    <= r_addr_q >> ADDR_WIDTH;
      r_issue_cnt <= r_issue_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                            r_protocol_error <= 1'b0;
    else if (bus.memRspValid && !w_rsp_ok) r_protocol_error <= 1'b1;
  end

  count_min_accumulator #(
    .NUM_HASHES  (NUM_HASHES),
    .COUNT_WIDTH (COUNT_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_accum (
    .clk       (clk),
    .rstb      (rstb),
    .i_clear   (w_accept),
    .i_update  (w_rsp_ok),
    .i_data    (bus.memRspData),
    .o_min     (w_min),
    .o_rsp_cnt (w_rsp_cnt),
    .o_done_c  (w_done_c)
  );

  // Outputs are decodes of registered state / registered data.
  assign bus.queryReady     = (r_state == IDLE);
  assign bus.memReadReq     = (r_state == ISSUE);
  assign bus.memReadAddr    = r_addr_q[ADDR_WIDTH-1:0];
  assign bus.resultValid    = (r_state == DONE);
  assign bus.resultMinimum  = w_min;
  assign bus.resultIsMember = (w_min != '0);
  assign busy               = (r_state != IDLE);
  assign protocolError      = r_protocol_error;

endmodule

// File: tb/tb_bloom_count_query_sequencer.sv
// Scoreboard bench: a RAM model answers granted reads in order, the query
// driver pushes the expected minimum, a monitor pops on each result handshake.
module tb_bloom_count_query_sequencer;
  import bloom_pkg::*;

  localparam int unsigned NH = 7;
  localparam int unsigned AW = 20;
  localparam int unsigned CW = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  bloom_count_query_sequencer_if #(.NUM_HASHES(NH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) ifc ();
  bloom_count_query_sequencer_if #(.NUM_HASHES(1),  .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) ifc1 ();
  logic busy, perr, busy1, perr1;

  bloom_count_query_sequencer #(.NUM_HASHES(NH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rstb(rstb), .bus(ifc.master), .busy(busy), .protocolError(perr));

  bloom_count_query_sequencer #(.NUM_HASHES(1), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut1 (
    .clk(clk), .rstb(rstb), .bus(ifc1.master), .busy(busy1), .protocolError(perr1));

  typedef struct {
    logic [CW-1:0] d;
    int            due;
  } rsp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [CW-1:0] mem [logic [AW-1:0]];
  rsp_t          rsp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_min_q[$];

  int gnt_mode    = 0;   // 0 always, 1 pattern 1,0,0, 2 random
  int gnt_phase   = 0;
  int lat_mode    = 0;   // 0 fixed latency 2, 1 random 1..4
  int last_due    = 0;
  bit rdy_always  = 1'b1;
  bit hold_mode   = 1'b0;
  bit spur_req    = 1'b0;
  bit lat_check   = 1'b0;
  bit b2b_check   = 1'b0;
  int acc_cyc     = 0;
  int hs_cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Counter RAM model: random grant, in-order responses after >=1 cycle.
  initial begin
    logic g;
    int   lat, due;
    logic [AW-1:0] a;
    ifc.memReadGnt  = 1'b0;
    ifc.memRspValid = 1'b0;
    ifc.memRspData  = '0;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        0:       g = 1'b1;
        1:       g = (gnt_phase % 3 == 0);
        default: g = 1'($urandom);
      endcase
      gnt_phase++;
      ifc.memReadGnt = g;
      if (rstb && ifc.memReadReq && g) begin
        if (exp_addr_q.size() == 0) fail("unexpected_read");
        else begin
          a = exp_addr_q.pop_front();
          chk("read_addr", 32'(ifc.memReadAddr), 32'(a));
        end
        lat = (lat_mode != 0) ? int'($urandom_range(1, 4)) : 2;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_q.push_back('{mem.exists(ifc.memReadAddr) ? mem[ifc.memReadAddr] : CW'(0), due});
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        ifc.memRspValid = 1'b1;
        ifc.memRspData  = rsp_q.pop_front().d;
      end else if (spur_req) begin
        ifc.memRspValid = 1'b1;
        ifc.memRspData  = CW'($urandom);
        spur_req        = 1'b0;
      end else begin
        ifc.memRspValid = 1'b0;
        ifc.memRspData  = CW'($urandom);
      end
    end
  end

  // Result monitor: drives resultReady and checks against the scoreboard.
  initial begin
    bit            prev_v;
    logic [CW-1:0] held;
    int            vcnt, e;
    logic          r;
    prev_v = 1'b0;
    held   = '0;
    vcnt   = 0;
    ifc.resultReady = 1'b0;
    forever begin
      @(negedge clk);
      if (rstb && ifc.resultValid) begin
        if (!prev_v) begin
          held = ifc.resultMinimum;
          vcnt = 0;
          if (lat_check) begin
            chk("result_latency", 32'(cyc - acc_cyc), 32'(NH + 2 + 1));
            lat_check = 1'b0;
          end
        end else begin
          chk("result_stable", 32'(ifc.resultMinimum), 32'(held));
        end
        chk("query_ready_in_done", 32'(ifc.queryReady), 32'(0));
        chk("read_req_in_done", 32'(ifc.memReadReq), 32'(0));
        if (hold_mode) r = (vcnt >= 5);
        else           r = rdy_always ? 1'b1 : 1'($urandom);
        ifc.resultReady = r;
        vcnt++;
        if (r) begin
          if (exp_min_q.size() == 0) fail("unexpected_result");
          else begin
            e = exp_min_q.pop_front();
            chk("result_min", 32'(ifc.resultMinimum), 32'(e));
            chk("result_member", 32'(ifc.resultIsMember), 32'(e != 0));
          end
          hs_cyc    = cyc;
          hold_mode = 1'b0;
          prev_v    = 1'b0;
        end else begin
          prev_v = 1'b1;
        end
      end else begin
        ifc.resultReady = 1'($urandom);
        prev_v          = 1'b0;
      end
    end
  end

  // Present one query; expected minimum is the plain min of the stored counters.
  task automatic send_query(input logic [NH*CW-1:0] vals);
    int            n;
    int            m;
    logic [AW-1:0] al [NH];
    n = 0;
    @(negedge clk);
    while (!ifc.queryReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.queryReady) begin
      fail("query_ready_timeout");
      return;
    end
    for (int i = 0; i < int'(NH); i++) begin
      al[i] = AW'($urandom);
      ifc.queryAddrs[i*AW +: AW] = al[i];
      mem[al[i]] = vals[i*CW +: CW];
    end
    m = (1 << CW) - 1;
    for (int i = 0; i < int'(NH); i++) begin
      exp_addr_q.push_back(al[i]);
      if (int'(mem[al[i]]) < m) m = int'(mem[al[i]]);
    end
    exp_min_q.push_back(m);
    if (b2b_check) begin
      chk("b2b_accept_cycle", 32'(cyc), 32'(hs_cyc + 1));
      b2b_check = 1'b0;
    end
    acc_cyc = cyc;
    ifc.queryValid = 1'b1;
    @(posedge clk);
    #1;
    ifc.queryValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_min_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_min_q.size() != 0 || busy) fail("idle_timeout");
  endtask

  // Single-hash build: one read, one response, result equals that counter.
  task automatic run1(input logic [CW-1:0] v);
    logic [AW-1:0] a;
    int            n;
    a = AW'($urandom);
    n = 0;
    @(negedge clk);
    while (!ifc1.queryReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    ifc1.queryAddrs  = a;
    ifc1.queryValid  = 1'b1;
    @(negedge clk);
    ifc1.queryValid  = 1'b0;
    chk("n1_read_req", 32'(ifc1.memReadReq), 32'(1));
    chk("n1_read_addr", 32'(ifc1.memReadAddr), 32'(a));
    @(negedge clk);
    chk("n1_drain_no_req", 32'(ifc1.memReadReq), 32'(0));
    ifc1.memRspValid = 1'b1;
    ifc1.memRspData  = v;
    @(negedge clk);
    ifc1.memRspValid = 1'b0;
    chk("n1_result_valid", 32'(ifc1.resultValid), 32'(1));
    chk("n1_result_min", 32'(ifc1.resultMinimum), 32'(v));
    chk("n1_result_member", 32'(ifc1.resultIsMember), 32'(v != 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    ifc.queryValid   = 1'b0;
    ifc.queryAddrs   = '0;
    ifc1.queryValid  = 1'b0;
    ifc1.queryAddrs  = '0;
    ifc1.memReadGnt  = 1'b1;
    ifc1.memRspValid = 1'b0;
    ifc1.memRspData  = '0;
    ifc1.resultReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result_valid", 32'(ifc.resultValid), 32'(0));
    chk("rst_read_req", 32'(ifc.memReadReq), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_query_ready", 32'(ifc.queryReady), 32'(1));
    chk("rst_protocol_error", 32'(perr), 32'(0));
    chk("rst_min_ones", 32'(ifc.resultMinimum), 32'(15));
    @(negedge clk);
    rstb = 1'b1;

    // Directed vectors, grant always high, latency 2 (LSB nibble is address 0).
    lat_check = 1'b1;
    send_query({4'd6, 4'd4, 4'd7, 4'd3, 4'd9, 4'd3, 4'd5});
    send_query({4'd4, 4'd1, 4'd1, 4'd8, 4'd0, 4'd2, 4'd2});
    send_query({4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15});
    wait_idle();

    // Grant pattern 1,0,0,...
    gnt_mode = 1;
    for (int i = 0; i < 3; i++) send_query((NH*CW)'($urandom));
    wait_idle();

    // Hold result 5 cycles, then back-to-back query.
    gnt_mode  = 0;
    hold_mode = 1'b1;
    send_query((NH*CW)'($urandom));
    b2b_check = 1'b1;
    send_query((NH*CW)'($urandom));
    wait_idle();

    // Randomized grant, latency and ready.
    gnt_mode   = 2;
    lat_mode   = 1;
    rdy_always = 1'b0;
    for (int i = 0; i < 30; i++) send_query((NH*CW)'($urandom));
    wait_idle();
    chk("no_false_protocol_error", 32'(perr), 32'(0));

    // Spurious response while idle.
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_protocol_error", 32'(perr), 32'(1));
    send_query({4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3});
    wait_idle();

    // Reset in the middle of ISSUE.
    gnt_mode = 1;
    send_query((NH*CW)'($urandom));
    n = 0;
    while (!ifc.memReadReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk("midrst_result_valid", 32'(ifc.resultValid), 32'(0));
    chk("midrst_read_req", 32'(ifc.memReadReq), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_query_ready", 32'(ifc.queryReady), 32'(1));
    chk("midrst_protocol_error", 32'(perr), 32'(0));
    rsp_q.delete();
    exp_addr_q.delete();
    exp_min_q.delete();
    last_due = 0;
    @(negedge clk);
    rstb       = 1'b1;
    gnt_mode   = 0;
    lat_mode   = 0;
    rdy_always = 1'b1;
    send_query({4'd12, 4'd11, 4'd10, 4'd2, 4'd13, 4'd14, 4'd15});
    wait_idle();
    chk("post_reset_protocol_error", 32'(perr), 32'(0));

    // Single-hash build.
    run1(4'd7);
    run1(4'd0);
    run1(4'd15);
    run1(4'd3);
    chk("n1_protocol_error", 32'(perr1), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
